// File: rtl/victim_cache_ctrl.sv
// Victim-cache sequencing controller: turns lookup/insert requests into tag-store
// strobe sequences, selects victim ways and issues write-backs for dirty evictions.
module victim_cache_ctrl #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS  = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_op,
    input  logic [TAG_WIDTH-1:0] i_req_tag,
    input  logic                 i_req_dirty,
    output logic                 o_resp_valid,
    output logic                 o_resp_hit,
    output logic [WAY_W-1:0]     o_resp_way,
    output logic                 o_resp_dirty,
    output logic                 o_resp_wb,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [TAG_WIDTH-1:0] o_wb_tag,
    output logic                 o_ts_write_en,
    output logic                 o_ts_read_en,
    output logic                 o_ts_lookup_en,
    output logic                 o_ts_valid_clear,
    output logic                 o_ts_dirty_set,
    output logic                 o_ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] o_ts_tag,
    output logic [WAY_W-1:0]     o_ts_way,
    input  logic                 i_ts_hit,
    input  logic [WAY_W-1:0]     i_ts_hit_way,
    input  logic                 i_ts_valid_rd,
    input  logic                 i_ts_dirty_rd,
    input  logic [TAG_WIDTH-1:0] i_ts_tag_rd
);

    typedef enum logic [3:0] {
        IDLE,
        LK_ISSUE,
        LK_EVAL,
        HIT_READ,
        HIT_EVAL,
        HIT_INV,
        INS_READ,
        INS_EVAL,
        WB,
        INS_WRITE,
        INS_DIRTY,
        RESP
    } state_t;

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic                   r_op;
    logic                   r_reqDirty;
    logic [WAY_W-1:0]       r_way;
    logic                   r_hit;
    logic                   r_hitDirty;
    logic                   r_wb;
    logic [TAG_WIDTH-1:0]   r_wbTag;
    logic [NUM_WAYS-1:0]    r_validMask;
    logic [WAY_W-1:0]       r_rrPtr;

    logic                   w_freeFound;
    logic [WAY_W-1:0]       w_freeWay;
    logic [WAY_W-1:0]       w_victim;

    // Descending scan so the lowest-index free way wins.
    always_comb begin
        w_freeFound = 1'b0;
        w_freeWay   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!r_validMask[i]) begin
                w_freeFound = 1'b1;
                w_freeWay   = WAY_W'(i);
            end
        end
    end

    assign w_victim = w_freeFound ? w_freeWay : r_rrPtr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_op        <= 1'b0;
            r_reqDirty  <= 1'b0;
            r_way       <= '0;
            r_hit       <= 1'b0;
            r_hitDirty  <= 1'b0;
            r_wb        <= 1'b0;
            r_wbTag     <= '0;
            r_validMask <= '0;
            r_rrPtr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_tag      <= i_req_tag;
                        r_op       <= i_req_op;
                        r_reqDirty <= i_req_dirty;
                        r_hit      <= 1'b0;
                        r_hitDirty <= 1'b0;
                        r_wb       <= 1'b0;
                        if (i_req_op) begin
                            r_way <= w_victim;
                            if (!w_freeFound) begin
                                r_rrPtr <= r_rrPtr + 1'b1;
                            end
                            r_state <= INS_READ;
                        end else begin
                            r_state <= LK_ISSUE;
                        end
                    end
                end
                LK_ISSUE: r_state <= LK_EVAL;
                LK_EVAL: begin
                    r_hit <= i_ts_hit;
                    if (i_ts_hit) begin
                        r_way   <= i_ts_hit_way;
                        r_state <= HIT_READ;
                    end else begin
                        r_state <= RESP;
                    end
                end
                HIT_READ: r_state <= HIT_EVAL;
                HIT_EVAL: begin
                    r_hitDirty <= i_ts_dirty_rd;
                    r_state    <= HIT_INV;
                end
                // The hit line migrates back to L1, so its way becomes free.
                HIT_INV: begin
                    r_validMask[r_way] <= 1'b0;
                    r_state            <= RESP;
                end
                INS_READ: r_state <= INS_EVAL;
                INS_EVAL: begin
                    if (i_ts_valid_rd && i_ts_dirty_rd) begin
                        r_wbTag <= i_ts_tag_rd;
                        r_wb    <= 1'b1;
                        r_state <= WB;
                    end else begin
                        r_state <= INS_WRITE;
                    end
                end
                WB: begin
                    if (i_wb_ready) begin
                        r_state <= INS_WRITE;
                    end
                end
                INS_WRITE: begin
                    r_validMask[r_way] <= 1'b1;
                    r_state            <= INS_DIRTY;
                end
                INS_DIRTY: r_state <= RESP;
                RESP:      r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready      = (r_state == IDLE);
    assign o_resp_valid     = (r_state == RESP);
    assign o_resp_hit       = o_resp_valid && !r_op && r_hit;
    assign o_resp_way       = o_resp_valid ? r_way : '0;
    assign o_resp_dirty     = o_resp_valid && r_hitDirty;
    assign o_resp_wb        = o_resp_valid && r_wb;
    assign o_wb_valid       = (r_state == WB);
    assign o_wb_tag         = r_wbTag;
    assign o_ts_lookup_en   = (r_state == LK_ISSUE);
    assign o_ts_read_en     = (r_state == HIT_READ) || (r_state == INS_READ);
    assign o_ts_valid_clear = (r_state == HIT_INV);
    assign o_ts_write_en    = (r_state == INS_WRITE);
    assign o_ts_dirty_set   = (r_state == INS_DIRTY) && r_reqDirty;
    assign o_ts_dirty_clear = (r_state == INS_DIRTY) && !r_reqDirty;
    assign o_ts_tag         = r_tag;
    assign o_ts_way         = r_way;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Randomized bench for victim_cache_ctrl: a tag-store responder plus an abstract
// cache model (lines, free ways, round-robin pointer) predicting every response.
module tb_victim_cache_ctrl;

    localparam int TAG_WIDTH = 4;
    localparam int NUM_WAYS  = 4;
    localparam int WAY_W     = 2;

    logic                 clk = 1'b0;
    logic                 rstN = 1'b1;
    logic                 reqValid = 1'b0;
    logic                 reqReady;
    logic                 reqOp = 1'b0;
    logic [TAG_WIDTH-1:0] reqTag = '0;
    logic                 reqDirty = 1'b0;
    logic                 respValid;
    logic                 respHit;
    logic [WAY_W-1:0]     respWay;
    logic                 respDirty;
    logic                 respWb;
    logic                 wbValid;
    logic                 wbReady = 1'b0;
    logic [TAG_WIDTH-1:0] wbTag;
    logic                 tsWriteEn, tsReadEn, tsLookupEn, tsValidClear, tsDirtySet, tsDirtyClear;
    logic [TAG_WIDTH-1:0] tsTag;
    logic [WAY_W-1:0]     tsWay;
    logic                 tsHit;
    logic [WAY_W-1:0]     tsHitWay;
    logic                 tsValidRd, tsDirtyRd;
    logic [TAG_WIDTH-1:0] tsTagRd;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.TAG_WIDTH(TAG_WIDTH), .NUM_WAYS(NUM_WAYS)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_op(reqOp),
        .i_req_tag(reqTag), .i_req_dirty(reqDirty),
        .o_resp_valid(respValid), .o_resp_hit(respHit), .o_resp_way(respWay),
        .o_resp_dirty(respDirty), .o_resp_wb(respWb),
        .o_wb_valid(wbValid), .i_wb_ready(wbReady), .o_wb_tag(wbTag),
        .o_ts_write_en(tsWriteEn), .o_ts_read_en(tsReadEn), .o_ts_lookup_en(tsLookupEn),
        .o_ts_valid_clear(tsValidClear), .o_ts_dirty_set(tsDirtySet), .o_ts_dirty_clear(tsDirtyClear),
        .o_ts_tag(tsTag), .o_ts_way(tsWay),
        .i_ts_hit(tsHit), .i_ts_hit_way(tsHitWay), .i_ts_valid_rd(tsValidRd),
        .i_ts_dirty_rd(tsDirtyRd), .i_ts_tag_rd(tsTagRd)
    );

    logic [5:0] strobes;
    assign strobes = {tsLookupEn, tsReadEn, tsWriteEn, tsValidClear, tsDirtySet, tsDirtyClear};

    // Tag store: strobes sampled at the clock edge, results visible the next cycle.
    logic                 storeValid [NUM_WAYS];
    logic                 storeDirty [NUM_WAYS];
    logic [TAG_WIDTH-1:0] storeTag   [NUM_WAYS];

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                storeValid[i] <= 1'b0;
                storeDirty[i] <= 1'b0;
                storeTag[i]   <= '0;
            end
            tsHit     <= 1'b0;
            tsHitWay  <= '0;
            tsValidRd <= 1'b0;
            tsDirtyRd <= 1'b0;
            tsTagRd   <= '0;
        end else begin
            if (tsLookupEn) begin
                tsHit <= 1'b0;
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (storeValid[i] && storeTag[i] == tsTag) begin
                        tsHit    <= 1'b1;
                        tsHitWay <= WAY_W'(i);
                    end
                end
            end
            if (tsReadEn) begin
                tsValidRd <= storeValid[tsWay];
                tsDirtyRd <= storeDirty[tsWay];
                tsTagRd   <= storeTag[tsWay];
            end
            if (tsWriteEn) begin
                storeValid[tsWay] <= 1'b1;
                storeTag[tsWay]   <= tsTag;
            end
            if (tsValidClear) storeValid[tsWay] <= 1'b0;
            if (tsDirtySet)   storeDirty[tsWay] <= 1'b1;
            if (tsDirtyClear) storeDirty[tsWay] <= 1'b0;
        end
    end

    // Abstract cache model.
    logic                 modelValid [NUM_WAYS];
    logic                 modelDirty [NUM_WAYS];
    logic [TAG_WIDTH-1:0] modelTag   [NUM_WAYS];
    int                   modelRr;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_WAYS; i++) begin
            modelValid[i] = 1'b0;
            modelDirty[i] = 1'b0;
            modelTag[i]   = '0;
        end
        modelRr = 0;
    endtask

    function automatic int modelFind(input logic [TAG_WIDTH-1:0] t);
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (modelValid[i] && modelTag[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic logic [TAG_WIDTH-1:0] pickFreshTag();
        logic [TAG_WIDTH-1:0] t;
        do t = TAG_WIDTH'($urandom_range(0, (1 << TAG_WIDTH) - 1)); while (modelFind(t) >= 0);
        return t;
    endfunction

    // Issues one request (called just after a negedge) and checks the whole transaction.
    task automatic applyStimulus(input bit op, input logic [TAG_WIDTH-1:0] tag, input bit dirty, input int stall);
        int expHit = 0, expWay = 0, expDirty = 0, expWb = 0, expLat;
        int v = -1;
        logic [TAG_WIDTH-1:0] expWbTag = '0;
        int cycles = 0, stallLeft = stall, wbSeen = 0;
        int lk = 0, rd = 0, wr = 0, vc = 0, ds = 0, dc = 0;
        bit got = 0;

        if (!op) begin
            v = modelFind(tag);
            if (v >= 0) begin
                expHit   = 1;
                expWay   = v;
                expDirty = modelDirty[v];
                modelValid[v] = 1'b0;
                expLat   = 6;
            end else begin
                expLat = 3;
            end
        end else begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (!modelValid[i] && v < 0) v = i;
            end
            if (v < 0) begin
                v = modelRr;
                modelRr = (modelRr + 1) % NUM_WAYS;
            end
            expWay   = v;
            expWb    = (modelValid[v] && modelDirty[v]) ? 1 : 0;
            expWbTag = modelTag[v];
            modelValid[v] = 1'b1;
            modelDirty[v] = dirty;
            modelTag[v]   = tag;
            expLat = expWb ? 6 + stall : 5;
        end

        checkOutput("req_ready_idle", reqReady, 1);
        reqValid = 1'b1;
        reqOp    = op;
        reqTag   = tag;
        reqDirty = dirty;
        @(posedge clk);
        #1 reqValid = 1'b0;

        while (!got && cycles < 60) begin
            @(negedge clk);
            cycles++;
            checkOutput("one_strobe", ($countones(strobes) <= 1), 1);
            lk += tsLookupEn; rd += tsReadEn; wr += tsWriteEn;
            vc += tsValidClear; ds += tsDirtySet; dc += tsDirtyClear;
            if (wbValid) begin
                wbSeen++;
                checkOutput("wb_tag", wbTag, expWbTag);
                checkOutput("no_write_in_wb", tsWriteEn, 0);
                if (stallLeft > 0) begin
                    wbReady = 1'b0;
                    stallLeft--;
                end else begin
                    wbReady = 1'b1;
                end
            end else begin
                wbReady = 1'b0;
            end
            if (tsWriteEn) begin
                checkOutput("write_way", tsWay, expWay);
                checkOutput("write_tag", tsTag, tag);
            end
            if (respValid) got = 1;
        end

        if (!got) begin
            checkOutput("resp_timeout", 0, 1);
            return;
        end
        checkOutput("latency", cycles, expLat);
        checkOutput("resp_hit", respHit, expHit);
        if (op || expHit) checkOutput("resp_way", respWay, expWay);
        checkOutput("resp_dirty", respDirty, expDirty);
        checkOutput("resp_wb", respWb, expWb);
        checkOutput("wb_issued", (wbSeen > 0), expWb);
        checkOutput("strobe_counts", (lk << 20) | (rd << 16) | (wr << 12) | (vc << 8) | (ds << 4) | dc,
                    ((op ? 0 : 1) << 20) | (((op || expHit) ? 1 : 0) << 16) | ((op ? 1 : 0) << 12)
                    | (expHit << 8) | (((op && dirty) ? 1 : 0) << 4) | ((op && !dirty) ? 1 : 0));
        @(negedge clk);
        checkOutput("resp_one_cycle", respValid, 0);
        checkOutput("ready_after_resp", reqReady, 1);
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        #2 rstN = 1'b1;
        @(negedge clk);
        modelReset();
    endtask

    initial begin
        logic [TAG_WIDTH-1:0] prior [NUM_WAYS];
        logic [TAG_WIDTH-1:0] t;
        int guard;

        modelReset();
        #1 rstN = 1'b0;
        #2;
        checkOutput("reset_ready", reqReady, 1);
        checkOutput("reset_resp", {respValid, respHit, respWay, respDirty, respWb}, 0);
        checkOutput("reset_wb", {wbValid, wbTag}, 0);
        checkOutput("reset_strobes", strobes, 0);
        checkOutput("reset_ts_addr", {tsTag, tsWay}, 0);
        @(negedge clk);
        rstN = 1'b1;

        // Fill, hit, repeated-miss and free-way reuse.
        applyStimulus(1, 4'hA, 0, 0);
        applyStimulus(1, 4'hB, 0, 0);
        applyStimulus(1, 4'hC, 0, 0);
        applyStimulus(1, 4'hD, 0, 0);
        applyStimulus(0, 4'hC, 0, 0);
        applyStimulus(0, 4'hC, 0, 0);
        applyStimulus(1, 4'hE, 1, 0);
        applyStimulus(0, 4'hE, 0, 0);

        // Dirty eviction with a stalled write-back.
        applyReset();
        applyStimulus(1, 4'h5, 1, 0);
        applyStimulus(1, 4'h7, 0, 0);
        applyStimulus(1, 4'h8, 0, 0);
        applyStimulus(1, 4'hA, 0, 0);
        applyStimulus(1, 4'h9, 0, 3);

        // Round-robin wrap after a full fill.
        applyReset();
        for (int i = 0; i < NUM_WAYS + 5; i++) applyStimulus(1, pickFreshTag(), 0, 0);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1)) begin
                applyStimulus(1, pickFreshTag(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            end else if ($urandom_range(0, 1)) begin
                applyStimulus(0, modelTag[$urandom_range(0, NUM_WAYS - 1)], 0, 0);
            end else begin
                applyStimulus(0, TAG_WIDTH'($urandom_range(0, (1 << TAG_WIDTH) - 1)), 0, 0);
            end
        end

        // Reset while a write-back is pending.
        applyReset();
        for (int i = 0; i < NUM_WAYS; i++) begin
            prior[i] = pickFreshTag();
            applyStimulus(1, prior[i], 1, 0);
        end
        t = pickFreshTag();
        reqValid = 1'b1;
        reqOp    = 1'b1;
        reqTag   = t;
        reqDirty = 1'b0;
        @(posedge clk);
        #1 reqValid = 1'b0;
        wbReady = 1'b0;
        guard = 0;
        while (!wbValid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wb_reached", wbValid, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("wb_drop_async", wbValid, 0);
        checkOutput("ready_in_reset", reqReady, 1);
        @(negedge clk);
        rstN = 1'b1;
        modelReset();
        checkOutput("no_resp_after_reset", respValid, 0);
        for (int i = 0; i < NUM_WAYS; i++) applyStimulus(0, prior[i], 0, 0);
        applyStimulus(0, t, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/victim_cache_ctrl.md
# victim_cache_ctrl

Sequencing controller that sits directly upstream of the victim-cache tag store and is its only master. It accepts lookup and insert requests from the L1 miss path and turns each into a fixed sequence of tag-store strobes. It chooses victim ways, issues a write-back for evicted dirty lines, and returns one response per request.

## Interface
- TAG_WIDTH, 4, tag bits; must match the tag store
- NUM_WAYS, 4, ways; power of two, ≥2; WAY_W = $clog2(NUM_WAYS)

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  1  0 = lookup, 1 = insert
- req_tag  in  TAG_WIDTH  request tag
- req_dirty  in  1  insert only: the incoming line is dirty
- resp_valid  out  1  one-cycle response pulse, no backpressure
- resp_hit  out  1  lookup hit; always 0 for insert
- resp_way  out  WAY_W  hit way (lookup) or filled way (insert)
- resp_dirty  out  1  dirty bit of the hit line
- resp_wb  out  1  insert caused a write-back
- wb_valid  out  1  dirty victim write-back request
- wb_ready  in  1  write-back accepted
- wb_tag  out  TAG_WIDTH  tag of the evicted dirty line
- ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear  out  1 each  tag-store strobes
- ts_tag  out  TAG_WIDTH  tag to the tag store
- ts_way  out  WAY_W  way index to the tag store
- ts_hit  in  1  tag-store lookup result
- ts_hit_way  in  WAY_W  tag-store hit way
- ts_valid_rd, ts_dirty_rd  in  1 each  tag-store read data
- ts_tag_rd  in  TAG_WIDTH  tag-store read data

## Operation
- **States:** IDLE, LK_ISSUE, LK_EVAL, HIT_READ, HIT_EVAL, HIT_INV, INS_READ, INS_EVAL, WB, INS_WRITE, INS_DIRTY, RESP.
- **Accept:** a request is accepted on a posedge with req_valid && req_ready. On acceptance the controller latches req_tag, req_op and req_dirty. For an insert it also latches the victim way.
- **Lookup path:**
  - IDLE → LK_ISSUE, which asserts ts_lookup_en with ts_tag = latched tag.
  - LK_EVAL samples ts_hit and ts_hit_way.
  - On a miss: → RESP.
  - On a hit: HIT_READ asserts ts_read_en on the hit way → HIT_EVAL latches ts_dirty_rd → HIT_INV asserts ts_valid_clear on that way and clears its mask bit → RESP.
  - A hit line moves back to L1, so it is always invalidated.
- **Victim select:** the controller keeps an internal valid mask, set on every insert and cleared on every invalidate.
  - If any mask bit is 0, the victim is the lowest-index free way.
  - Otherwise the victim is rr_ptr, and rr_ptr increments modulo NUM_WAYS at acceptance.
- **Insert path:**
  - INS_READ asserts ts_read_en on the victim way.
  - INS_EVAL: if ts_valid_rd && ts_dirty_rd, latch ts_tag_rd into wb_tag and go to WB; otherwise go to INS_WRITE.
  - WB holds wb_valid until wb_valid && wb_ready, then goes to INS_WRITE.
  - INS_WRITE asserts ts_write_en with tag and way, and sets the mask bit.
  - INS_DIRTY asserts ts_dirty_set if req_dirty, else ts_dirty_clear → RESP.
- **RESP:** drives resp_valid = 1 for one cycle with all resp_* fields valid, then → IDLE.
- **Strobe decoding:** all ts_* strobes are decoded from the state register. Each strobe is high for exactly one cycle, and at most one strobe is high per cycle. ts_tag and ts_way hold the latched values, so they are stable across every strobe.
- **Duplicate tags:** the caller guarantees an inserted tag is not already resident. The controller does no deduplication.

## Timing
- **Tag-store timing:** a strobe asserted in cycle n is sampled by the tag store at the end of n. Its result is read in cycle n+1 (the EVAL state).
- **Latency** (acceptance edge to the resp_valid cycle):
  - Lookup miss: 3 cycles.
  - Lookup hit: 6 cycles.
  - Insert without write-back: 5 cycles.
  - Insert with write-back: 6 + wb stall cycles (wb_ready low).
- **WB handshake:** wb_valid and wb_tag stay stable until accepted. A write-back issued with wb_ready already high costs exactly 1 extra cycle.
- **Back-to-back requests:** req_ready rises in the cycle after RESP, so requests issue back-to-back with no extra bubble.
- **Reset values:**
  - State is IDLE; req_ready = 1.
  - All resp_*, wb_*, ts_* strobes, ts_tag and ts_way are 0.
  - Valid mask is all 0; rr_ptr is 0.
- **Reset mid-operation:** rst_n assertion anywhere, including WB, returns immediately to IDLE. Any pending write-back is dropped with no response.
- **Wrap-around:** rr_ptr wraps from NUM_WAYS-1 to 0.

## Test plan
- **Fill:** reset, insert tags A, B, C, D clean → resp_way 0, 1, 2, 3 in order; resp_wb = 0; each resp_valid exactly 5 cycles after acceptance.
- **Hit:** after the fill, lookup C → resp_hit = 1, resp_way = 2, resp_dirty = 0, 6-cycle latency. A repeated lookup of C → resp_hit = 0 (miss latency 3).
- **Free-way reuse:** after C is invalidated, insert E with req_dirty = 1 → resp_way = 2. A lookup of E → resp_dirty = 1.
- **Dirty eviction:** fill all ways with way 0 dirty (tag 5), then insert 9 → wb_valid with wb_tag = 5. Hold wb_ready low for 3 cycles: wb_valid stays high and no ts_write_en is issued. Then resp_wb = 1, resp_way = 0.
- **Round-robin:** fill all ways, then perform five consecutive clean inserts → victims 0, 1, 2, 3, 0.
- **Reset in WB:** assert rst_n low while wb_valid = 1 → wb_valid drops asynchronously, and after release req_ready = 1. A lookup of any prior tag → miss.
